// File: rtl/twiddle_factor_seq_if.sv
// Twiddle-factor output stream: valid/ready handshake plus the FP16 factor
// and the (stage, butterfly, k) coordinates of the entry being offered.
interface twiddle_factor_seq_if #(
  parameter int LOG2_NMAX = 4,
  parameter int KW        = LOG2_NMAX - 1
);
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   W_real;
  logic [15:0]   W_imag;
  logic [KW-1:0] out_k;
  logic [2:0]    out_stage;
  logic [KW-1:0] out_bfly;
  logic          out_last;

  modport master (
    output out_valid, W_real, W_imag, out_k, out_stage, out_bfly, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, W_real, W_imag, out_k, out_stage, out_bfly, out_last,
    output out_ready
  );
endinterface

// File: rtl/twiddle_factor_seq.sv
// Sequenced radix-2 DIT twiddle-factor generator.
// Streams W_N^k in FP16 for every (stage, butterfly) of an N = 2^n_log2 run,
// deriving each factor from a quarter-wave cosine table by symmetry.
//
// state | meaning
// IDLE  | waiting for start; output register empty
// RUN   | output register holds a valid entry, advancing on each transfer
module twiddle_factor_seq #(
  parameter int LOG2_NMAX = 4,
  parameter int KW        = LOG2_NMAX - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                fftorifft,
  input  logic [2:0]          n_log2,
  output logic                busy,
  output logic                done,
  output logic                err,
  twiddle_factor_seq_if.master tw
);

  localparam logic [2:0]  NMAX_L = 3'(LOG2_NMAX);
  // Quarter-wave table length Q = 2^LOG2_NMAX / 4 = 2^(KW-1)
  localparam logic [KW:0] QQ     = (KW+1)'(1) << (KW - 1);
  // The master table is cos(pi*t/64), t = 0..32 (the Q = 32 case); smaller
  // Q values pick every 2^TSH-th entry of it.
  localparam int          TSH    = 7 - LOG2_NMAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic       mode;
  logic [2:0] nl;

  function automatic logic [15:0] cos_rom(input logic [5:0] t);
    logic [15:0] v;
    case (t)
      6'd0:  v = 16'h3C00;
      6'd1:  v = 16'h3BFE;
      6'd2:  v = 16'h3BF6;
      6'd3:  v = 16'h3BEA;
      6'd4:  v = 16'h3BD9;
      6'd5:  v = 16'h3BC3;
      6'd6:  v = 16'h3BA8;
      6'd7:  v = 16'h3B88;
      6'd8:  v = 16'h3B64;
      6'd9:  v = 16'h3B3B;
      6'd10: v = 16'h3B0E;
      6'd11: v = 16'h3ADD;
      6'd12: v = 16'h3AA7;
      6'd13: v = 16'h3A6D;
      6'd14: v = 16'h3A2F;
      6'd15: v = 16'h39ED;
      6'd16: v = 16'h39A8;
      6'd17: v = 16'h395F;
      6'd18: v = 16'h3913;
      6'd19: v = 16'h38C4;
      6'd20: v = 16'h3872;
      6'd21: v = 16'h381D;
      6'd22: v = 16'h378B;
      6'd23: v = 16'h36D7;
      6'd24: v = 16'h361F;
      6'd25: v = 16'h3564;
      6'd26: v = 16'h34A5;
      6'd27: v = 16'h33C6;
      6'd28: v = 16'h323E;
      6'd29: v = 16'h30B2;
      6'd30: v = 16'h2E46;
      6'd31: v = 16'h2A48;
      6'd32: v = 16'h0000;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  // C[m] for m = 0..Q in this instance's table units
  function automatic logic [15:0] c_at(input logic [KW:0] m);
    logic [6:0] t;
    t = 7'(m) << TSH;
    return cos_rom(t[5:0]);
  endfunction

  // Sign flip that never turns +0 into -0
  function automatic logic [15:0] neg(input logic [15:0] x);
    return (x == 16'h0000) ? x : {~x[15], x[14:0]};
  endfunction

  function automatic logic [31:0] twiddle(input logic [KW-1:0] k,
                                          input logic [2:0]    nlog,
                                          input logic          inv);
    logic [KW:0]  kk;
    logic [15:0]  re;
    logic [15:0]  im;
    kk = {1'b0, k} << (NMAX_L - nlog);
    if (kk <= QQ) begin
      re = c_at(kk);
      im = c_at(QQ - kk);
    end else begin
      re = neg(c_at((QQ << 1) - kk));
      im = c_at(kk - QQ);
    end
    if (!inv) im = neg(im);
    return {re, im};
  endfunction

  // k = (b mod 2^s) * N / 2^(s+1); the mask wraps to all-ones when s = KW
  function automatic logic [KW-1:0] k_of(input logic [2:0]    s,
                                         input logic [KW-1:0] b,
                                         input logic [2:0]    nlog);
    logic [KW-1:0] mask;
    mask = (KW'(1) << s) - KW'(1);
    return (b & mask) << (nlog - 3'd1 - s);
  endfunction

  logic [KW:0]   half;
  logic [KW-1:0] bmax;
  logic [KW-1:0] nxt_b;
  logic [KW-1:0] nxt_k;
  logic [2:0]    nxt_s;
  logic          nxt_last;
  logic [31:0]   nxt_w;

  // Successor of the entry currently held in the output register
  always_comb begin
    half = (KW+1)'(1) << (nl - 3'd1);
    bmax = KW'(half - (KW+1)'(1));
    if (tw.out_bfly == bmax) begin
      nxt_b = '0;
      nxt_s = tw.out_stage + 3'd1;
    end else begin
      nxt_b = tw.out_bfly + KW'(1);
      nxt_s = tw.out_stage;
    end
    nxt_last = (nxt_s == nl - 3'd1) && (nxt_b == bmax);
    nxt_k    = k_of(nxt_s, nxt_b, nl);
    nxt_w    = twiddle(nxt_k, nl, mode);
  end

  // Sequencer FSM with the output register as its only pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode         <= 1'b0;
      nl           <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tw.out_valid <= 1'b0;
      tw.out_last  <= 1'b0;
      tw.W_real    <= 16'h0000;
      tw.W_imag    <= 16'h0000;
      tw.out_k     <= '0;
      tw.out_stage <= 3'd0;
      tw.out_bfly  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_log2 != 3'd0 && n_log2 <= NMAX_L) begin
              mode         <= fftorifft;
              nl           <= n_log2;
              // Entry (0,0) is always k = 0: W = 1 + j0
              tw.out_stage <= 3'd0;
              tw.out_bfly  <= '0;
              tw.out_k     <= '0;
              tw.W_real    <= 16'h3C00;
              tw.W_imag    <= 16'h0000;
              tw.out_last  <= (n_log2 == 3'd1);
              tw.out_valid <= 1'b1;
              busy         <= 1'b1;
              state        <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (tw.out_valid && tw.out_ready) begin
            if (tw.out_last) begin
              tw.out_valid <= 1'b0;
              tw.out_last  <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end else begin
              tw.out_stage <= nxt_s;
              tw.out_bfly  <= nxt_b;
              tw.out_k     <= nxt_k;
              tw.W_real    <= nxt_w[31:16];
              tw.W_imag    <= nxt_w[15:0];
              tw.out_last  <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_factor_seq.sv
// Bench for twiddle_factor_seq: a real-arithmetic reference (cos/sin of
// 2*pi*k/N rounded to FP16) generates the expected stream per run; a compare
// process checks every offered entry and the done pulse each cycle.
module tb_twiddle_factor_seq;
  localparam int  LOG2_NMAX = 4;
  localparam int  KW        = LOG2_NMAX - 1;
  localparam real PI        = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       fftorifft = 1'b0;
  logic [2:0] n_log2 = 3'd0;
  logic       busy, done, err;

  twiddle_factor_seq_if #(.LOG2_NMAX(LOG2_NMAX)) tw ();

  twiddle_factor_seq #(.LOG2_NMAX(LOG2_NMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fftorifft(fftorifft),
    .n_log2(n_log2), .busy(busy), .done(done), .err(err), .tw(tw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          k;
    int          s;
    int          b;
    logic        last;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   xfer_cnt = 0;
  logic exp_done_next = 1'b0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Round a real in [-1,1] to FP16, nearest-even; tiny magnitudes give +0
  function automatic logic [15:0] to_fp16(input real v);
    real m, p, sc, fl;
    int  e, iv;
    logic [15:0] r;
    m = (v < 0.0) ? -v : v;
    if (m < 1.0e-9) return 16'h0000;
    p = 1.0;
    e = 0;
    while (m < p) begin p = p / 2.0; e--; end
    while (m >= 2.0 * p) begin p = p * 2.0; e++; end
    sc = m / p * 1024.0;
    fl = $floor(sc);
    iv = $rtoi(fl);
    if ((sc - fl) > 0.5 || ((sc - fl) == 0.5 && (iv % 2) == 1)) iv++;
    if (iv == 2048) begin iv = 1024; e++; end
    r = 16'(((e + 15) << 10) | (iv - 1024));
    if (v < 0.0) r[15] = 1'b1;
    return r;
  endfunction

  task automatic gen_run(input int nl, input bit inv);
    int   n;
    ent_t e;
    real  th;
    n = 1 << nl;
    for (int s = 0; s < nl; s++) begin
      for (int b = 0; b < n / 2; b++) begin
        e.k    = (b % (1 << s)) * n / (1 << (s + 1));
        th     = 2.0 * PI * e.k / n;
        e.re   = to_fp16($cos(th));
        e.im   = to_fp16(inv ? $sin(th) : -$sin(th));
        e.s    = s;
        e.b    = b;
        e.last = (s == nl - 1) && (b == n / 2 - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Consumer handshake
  initial begin
    tw.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tw.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every offered entry against the model, done each cycle
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done_next = 1'b0;
      end else begin
        chk("done", done, exp_done_next);
        exp_done_next = 1'b0;
        if (tw.out_valid) begin
          chk("entry_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("w_real", tw.W_real, e.re);
            chk("w_imag", tw.W_imag, e.im);
            chk("out_k", tw.out_k, e.k[KW-1:0]);
            chk("out_stage", tw.out_stage, e.s[2:0]);
            chk("out_bfly", tw.out_bfly, e.b[KW-1:0]);
            chk("out_last", tw.out_last, e.last);
            if (tw.out_ready) begin
              exp_done_next = e.last;
              void'(exp_q.pop_front());
              xfer_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", seen, 1);
  endtask

  // Starts a run at the current time; returns at the negedge of the done cycle
  task automatic run(input int nl, input bit inv, input bit poke);
    gen_run(nl, inv);
    fftorifft = inv;
    n_log2    = 3'(nl);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", tw.out_valid, 1);
    if (poke) begin
      @(posedge clk);
      #1;
      start     = 1'b1;
      fftorifft = ~inv;
      n_log2    = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("err_in_run", err, 0);
      chk("busy_in_run", busy, 1);
    end
    wait_done();
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reject(input int nl);
    @(posedge clk);
    #1;
    n_log2 = 3'(nl);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("busy_rejected", busy, 0);
    chk("valid_rejected", tw.out_valid, 0);
    @(posedge clk);
    #1;
    chk("err_one_cycle", err, 0);
  endtask

  initial begin
    bit seen;
    int nl;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", tw.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_last", tw.out_last, 0);
    chk("rst_w_real", tw.W_real, 0);
    chk("rst_w_imag", tw.W_imag, 0);
    chk("rst_k", tw.out_k, 0);
    chk("rst_stage", tw.out_stage, 0);
    chk("rst_bfly", tw.out_bfly, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the reference model to hand-computed values
    gen_run(3, 0);
    chk("pin_n8_len", exp_q.size(), 12);
    chk("pin_n8_k5", exp_q[5].k, 2);
    chk("pin_n8_k1_re", exp_q[9].re, 16'h39A8);
    chk("pin_n8_k1_im", exp_q[9].im, 16'hB9A8);
    chk("pin_n8_k2_re", exp_q[10].re, 16'h0000);
    chk("pin_n8_k2_im", exp_q[10].im, 16'hBC00);
    chk("pin_n8_k3_re", exp_q[11].re, 16'hB9A8);
    chk("pin_n8_k3_im", exp_q[11].im, 16'hB9A8);
    chk("pin_n8_last", exp_q[11].last, 1);
    chk("pin_n8_notlast", exp_q[10].last, 0);
    exp_q.delete();
    gen_run(3, 1);
    chk("pin_i8_k0_im", exp_q[0].im, 16'h0000);
    chk("pin_i8_k1_im", exp_q[9].im, 16'h39A8);
    chk("pin_i8_k2_im", exp_q[10].im, 16'h3C00);
    chk("pin_i8_k2_re", exp_q[10].re, 16'h0000);
    chk("pin_i8_k3_im", exp_q[11].im, 16'h39A8);
    exp_q.delete();
    gen_run(4, 0);
    chk("pin_n16_len", exp_q.size(), 32);
    chk("pin_n16_k1", exp_q[25].k, 1);
    chk("pin_n16_k1_re", exp_q[25].re, 16'h3B64);
    chk("pin_n16_k1_im", exp_q[25].im, 16'hB61F);
    chk("pin_n16_k5", exp_q[29].k, 5);
    chk("pin_n16_k5_re", exp_q[29].re, 16'hB61F);
    chk("pin_n16_k5_im", exp_q[29].im, 16'hBB64);
    exp_q.delete();

    // Directed runs, back to back (each new start lands in the done cycle)
    run(3, 0, 1);
    run(3, 1, 0);
    run(4, 0, 1);
    run(4, 1, 0);

    reject(0);
    reject(5);
    reject(7);

    // Backpressure
    rand_ready = 1'b1;
    @(posedge clk);
    #1;
    run(3, 0, 1);
    run(3, 1, 0);
    run(4, 1, 1);
    rand_ready = 1'b0;

    // Random runs
    for (int i = 0; i < 10; i++) begin
      nl = $urandom_range(1, LOG2_NMAX);
      run(nl, 1'($urandom_range(0, 1)), nl >= 3);
      rand_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;

    // Reset in the middle of a run
    @(posedge clk);
    #1;
    xfer_cnt  = 0;
    gen_run(4, 0);
    fftorifft = 1'b0;
    n_log2    = 3'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (xfer_cnt >= 5) begin seen = 1'b1; break; end
    end
    chk("five_transfers", seen, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tw.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_last", tw.out_last, 0);
    chk("mid_rst_w_real", tw.W_real, 0);
    chk("mid_rst_w_imag", tw.W_imag, 0);
    chk("mid_rst_k", tw.out_k, 0);
    chk("mid_rst_stage", tw.out_stage, 0);
    chk("mid_rst_bfly", tw.out_bfly, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_done", done, 0);
    run(3, 0, 0);
    run(2, 1, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twiddle_factor_seq.md
# twiddle_factor_seq

Parametrised, sequenced twiddle-factor generator for the radix-2 DIT FFT/IFFT datapath. The transform length N = 2^n_log2 is selectable at run time, up to 2^LOG2_NMAX. For each stage and butterfly, in order, it streams the matching W_N^k in IEEE 754 half precision over a valid/ready interface. Factors are derived from a quarter-wave cosine table by symmetry. The direction (FFT or IFFT) is latched per run.

## Interface
- LOG2_NMAX, 4: log2 of the largest supported N; legal range 3..7.
- KW, LOG2_NMAX-1: width of the k and butterfly indices (derived; do not override).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- fftorifft  in  1  0 = FFT (W = cos − j·sin); 1 = IFFT (W = cos + j·sin); latched on an accepted start.
- n_log2  in  3  log2 N for the run; latched on an accepted start.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry when out_valid & out_ready.
- W_real, W_imag  out  16 each  twiddle factor in FP16.
- out_k  out  KW  twiddle exponent k, in units of the run's N.
- out_stage  out  3  stage index s.
- out_bfly  out  KW  butterfly index b within the stage.
- out_last  out  1  marks the final entry of the run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last transfer.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- **ROM.** C[m] = cos(π·m / (2·Q)), with Q = 2^LOG2_NMAX / 4 and m = 0..Q, rounded to the nearest FP16 (ties to even). Build it as a constant case statement.
  - Entries for N = 16: C[0] = 3C00, C[1] = 3B64, C[2] = 39A8, C[3] = 361F, C[4] = 0000.
- **Index scaling.** Convert k in N units to table units with kk = k << (LOG2_NMAX − n_log2). Let QQ = Q.
- **Magnitudes.**
  - If kk ≤ QQ: re = C[kk], im = C[QQ − kk].
  - Otherwise: re = −C[2·QQ − kk], im = C[kk − QQ].
- **Signs.**
  - Negation is a sign-bit flip, and is never applied to 0x0000.
  - The imaginary part is negated when fftorifft = 0.
- **Sequence.**
  - Order: s = 0..n_log2−1 (outer loop), b = 0..N/2−1 (inner loop).
  - k = (b mod 2^s) · N / 2^(s+1).
  - A run contains n_log2 · N/2 entries.
  - out_last = 1 when s = n_log2−1 and b = N/2−1.
- **IDLE state.**
  - start with 1 ≤ n_log2 ≤ LOG2_NMAX:
    - latch the mode and n_log2;
    - load the output register with entry (0,0);
    - set out_valid;
    - go to RUN.
  - start with n_log2 = 0 or n_log2 > LOG2_NMAX: pulse err and stay in IDLE.
- **RUN state.**
  - On a transfer of a non-last entry, load the next entry in the same edge, so out_valid stays high.
  - On a transfer of the last entry, clear out_valid, pulse done and go to IDLE.
  - With out_valid high and out_ready low, every output holds stable.
  - start is ignored: no err, and no change to the latched mode or n_log2.
- **Inputs during a run.** Changes to fftorifft or n_log2 have no effect until the next accepted start.

## Timing
- Reset (async assert, sync release) sets:
  - state = IDLE;
  - out_valid, busy, done, err, out_last = 0;
  - W_real, W_imag, out_k, out_stage, out_bfly = 0.
- Latency: start is sampled at edge t, and entry (0,0) with out_valid = 1 is visible after edge t.
- Throughput: one entry per cycle while out_ready = 1.
- Run length with out_ready held high: n_log2 · N/2 cycles of out_valid.
- done is high for the single cycle following the last transfer edge. busy is low in that same cycle, so a new start can be accepted there.
- err is high for the single cycle following the rejecting edge.
- A start in the cycle done is high is legal and starts a new run.
- If rst_n asserts mid-run, out_valid drops immediately and the partial run is discarded; done is not pulsed.
- The output register is the only stage: no combinational path from out_ready to out_valid, W_real or W_imag.

## Test plan
- **N = 8 FFT (n_log2 = 3, out_ready = 1).** Twelve entries.
  - k sequence: 0,0,0,0 | 0,2,0,2 | 0,1,2,3.
  - k = 1 → 39A8/B9A8; k = 2 → 0000/BC00; k = 3 → B9A8/B9A8.
  - out_last only on the 12th entry; done on the next cycle.
- **N = 8 IFFT.** Same k sequence. Imaginary parts become 39A8 (k = 1), 3C00 (k = 2), 39A8 (k = 3); real parts unchanged. 0x0000 is never emitted as 0x8000.
- **N = 16 FFT.** The last stage emits k = 0..7.
  - k = 1 → 3B64/B61F; k = 5 → B61F/BB64.
  - 32 entries total.
- **Backpressure.** Toggle out_ready pseudo-randomly during N = 8. Outputs are stable while stalled. The entry order is identical to the unstalled run, with no drops or duplicates.
- **Rejects.**
  - start with n_log2 = 0 or 5 (LOG2_NMAX = 4): err pulse, busy stays 0.
  - start during RUN: ignored, with no err and no change to the mode.
- **Reset mid-run.** Assert rst_n low at entry 5 of a run: outputs return to their reset values asynchronously. A new start after release begins again at entry (0,0).
